// File: rtl/fifo_sync_wm_if.sv
// Handshake and status bundle for fifo_sync_wm.
// The master side issues reads and writes. The slave side (the FIFO) returns
// data and status.
interface fifo_sync_wm_if #(
  parameter int BIT_WIDTH = 16,
  parameter int CW        = 4
);
  logic                 read_en;
  logic [BIT_WIDTH-1:0] read_data;
  logic                 read_valid;
  logic                 write_en;
  logic [BIT_WIDTH-1:0] write_data;
  logic                 clear_stat;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic                 almost_empty;
  logic                 almost_full;
  logic [CW-1:0]        count;
  logic [CW-1:0]        max_count;
  logic                 overflow;
  logic                 underflow;

  modport master (
    output read_en, write_en, write_data, clear_stat,
    input  read_data, read_valid, fifo_empty, fifo_full, almost_empty,
           almost_full, count, max_count, overflow, underflow
  );

  modport slave (
    input  read_en, write_en, write_data, clear_stat,
    output read_data, read_valid, fifo_empty, fifo_full, almost_empty,
           almost_full, count, max_count, overflow, underflow
  );
endinterface

// File: rtl/fifo_sync_wm.sv
// Synchronous flop-based FIFO for activation and partial-sum buffering.
// Features:
// - The depth does not have to be a power of two.
// - The occupancy count is explicit.
// - Almost-full and almost-empty thresholds are programmable.
// - The read port is either show-ahead or registered.
// - Overflow and underflow flags are sticky.
// - A high-watermark tracker records the peak occupancy.
module fifo_sync_wm #(
  parameter int BIT_WIDTH          = 16,
  parameter int FIFO_DEPTH         = 12,
  parameter int ALMOST_FULL_THRES  = 10,
  parameter int ALMOST_EMPTY_THRES = 2,
  parameter int READ_MODE          = 0
) (
  input logic           clk,
  input logic           rst,
  fifo_sync_wm_if.slave bus
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);

  logic [BIT_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic [CW-1:0]        max_count_q, max_count_d;
  logic                 overflow_q, overflow_d;
  logic                 underflow_q, underflow_d;
  logic                 fifo_empty, fifo_full, rd_acc, wr_acc;

  // Status comes from the registered count only, so it never depends on read_en or write_en.
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));

  // A read is accepted only when data is present.
  // When full, a write is accepted only if a read frees a slot in the same cycle.
  assign rd_acc = bus.read_en & ~fifo_empty;
  assign wr_acc = bus.write_en & (~fifo_full | rd_acc);

  assign bus.fifo_empty   = fifo_empty;
  assign bus.fifo_full    = fifo_full;
  assign bus.almost_empty = (count_q <= CW'(ALMOST_EMPTY_THRES));
  assign bus.almost_full  = (count_q >= CW'(ALMOST_FULL_THRES));
  assign bus.count        = count_q;
  assign bus.max_count    = max_count_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

  // Next-state logic for the pointers, occupancy and statistics.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PW'(1);
    if (rd_acc) rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PW'(1);
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // A new error wins over clear_stat in the same cycle.
    overflow_d  = (bus.write_en & ~wr_acc) | (overflow_q & ~bus.clear_stat);
    underflow_d = (bus.read_en & fifo_empty) | (underflow_q & ~bus.clear_stat);
    // On clear_stat, the watermark restarts from the occupancy it is about to have.
    max_count_d = (bus.clear_stat || (count_d > max_count_q)) ? count_d : max_count_q;
  end

  // Control and statistics registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values.
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      max_count_q <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      max_count_q <= max_count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage array. A write at full plus a read replaces the slot being read.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset. A reset clears count and pointers, so stale words are never visible.
    if (wr_acc) mem_q[wr_ptr_q] <= bus.write_data;
  end

  if (READ_MODE == 0) begin : g_show_ahead
    assign bus.read_data  = fifo_empty ? '0 : mem_q[rd_ptr_q];
    assign bus.read_valid = ~fifo_empty;
  end else begin : g_registered
    logic [BIT_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                 rd_valid_q, rd_valid_d;

    // Capture the head word on an accepted read. Otherwise hold the data and drop valid.
    always_comb begin
      rd_data_d  = rd_data_q;
      rd_valid_d = rd_acc;
      if (rd_acc) rd_data_d = mem_q[rd_ptr_q];
    end

    // Registered read port, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_data_q  <= rd_data_d;
        rd_valid_q <= rd_valid_d;
      end
    end

    assign bus.read_data  = rd_data_q;
    assign bus.read_valid = rd_valid_q;
  end
endmodule

// File: doc/fifo_sync_wm.md
Name: fifo_sync_wm

Overview:
- Parametrised synchronous FIFO and successor to the basic register FIFO, for inter-layer activation and partial-sum buffering.
- Adds the following over the basic FIFO:
  - non-power-of-two depth
  - occupancy count output
  - programmable almost-full and almost-empty thresholds
  - selectable show-ahead or registered read port
  - correct simultaneous read/write at full
  - sticky overflow and underflow error flags
  - synthesizable high-watermark tracker, replacing simulation-only depth counters
- Memory is DFF-based.

Parameters:
- BIT_WIDTH, 16, data width in bits (>=1).
- FIFO_DEPTH, 12, number of entries (>=2; need not be a power of two).
- ALMOST_FULL_THRES, 10, almost_full asserts when count >= this value (1..FIFO_DEPTH).
- ALMOST_EMPTY_THRES, 2, almost_empty asserts when count <= this value (0..FIFO_DEPTH-1).
- READ_MODE, 0, read port style:
  - 0 = show-ahead combinational
  - 1 = registered, 1-cycle latency

Ports:
- clk  input  1  system clock
- rst  input  1  system reset, asynchronous, active-high
- read_en  input  1  read request
- read_data  output  BIT_WIDTH  read data
- read_valid  output  1  read_data holds a popped word
- write_en  input  1  write request
- write_data  input  BIT_WIDTH  write data
- clear_stat  input  1  synchronous clear of the overflow, underflow and max_count statistics
- fifo_empty  output  1  count == 0
- fifo_full  output  1  count == FIFO_DEPTH
- almost_empty  output  1  count <= ALMOST_EMPTY_THRES
- almost_full  output  1  count >= ALMOST_FULL_THRES
- count  output  CW = clog2(FIFO_DEPTH+1)  current occupancy
- max_count  output  CW  highest count reached since reset or clear_stat
- overflow  output  1  sticky: write_en seen while the write could not be accepted
- underflow  output  1  sticky: read_en seen while empty

Behaviour:
- Reset (async, rst=1), all outputs and state go to:
  - pointers = 0, count = 0, max_count = 0
  - fifo_empty = 1, fifo_full = 0
  - almost_empty = 1; almost_full = 0
  - overflow = 0, underflow = 0
  - read_data = 0, read_valid = 0
  - Memory contents are not reset.
  - Reset asserted mid-operation discards all contents immediately.
- Acceptance (combinational, evaluated from registered state):
  - rd_acc = read_en & ~fifo_empty
  - wr_acc = write_en & (~fifo_full | rd_acc)
  - Write while full with simultaneous read: both are accepted and count is unchanged. The read returns the old word in that slot; the new word is stored in the same slot.
  - Write while empty with simultaneous read: write accepted, read rejected, underflow set.
- Pointers:
  - Advance by 1 on accept and wrap from FIFO_DEPTH-1 to 0.
  - Full and empty are never inferred from pointer equality.
- Count:
  - +1 on wr_acc only, -1 on rd_acc only, unchanged on both or neither.
  - fifo_empty, fifo_full, almost_empty and almost_full are decoded from the registered count only. There is no combinational path from read_en or write_en to any status output.
- Write: on wr_acc, mem[write_ptr] <= write_data at the clock edge.
- READ_MODE 0:
  - read_data = mem[read_ptr] whenever ~fifo_empty, else 0. Not gated by read_en.
  - read_valid = ~fifo_empty.
  - The pop takes effect at the edge where rd_acc = 1.
- READ_MODE 1:
  - On rd_acc, read_data <= mem[read_ptr] and read_valid <= 1 at that edge.
  - If not rd_acc, read_valid <= 0 and read_data holds its last value.
  - Latency is 1 cycle from the read_en sample to valid data.
- Statistics:
  - overflow <= 1 when write_en & ~wr_acc.
  - underflow <= 1 when read_en & fifo_empty.
  - max_count <= next_count when next_count > max_count.
  - clear_stat = 1 zeroes overflow, underflow and max_count at the next edge. If an error occurs in the same cycle as clear_stat, the error takes priority and the flag is set. During clear_stat, max_count loads next_count rather than 0.
  - Statistics never affect data flow.

Test Plan:
- FIFO_DEPTH=12, READ_MODE=0: write 0x0001..0x000C with no reads.
  - Expected: count steps 1..12; almost_full rises in the cycle count becomes 10; fifo_full = 1 at 12; max_count = 12.
  - Then read 12 words: read_data = 0x0001..0x000C in order; fifo_empty = 1; almost_empty rises at count 2.
- Full, read and write together: simultaneous read_en and write_en with write_data = 0xBEEF.
  - Expected: count stays 12, fifo_full stays 1, overflow stays 0; read returns the oldest word; 0xBEEF emerges 12 reads later.
- Overflow/underflow:
  - write_en while full with no read: overflow = 1 and sticky; the data is dropped (the next 12 reads do not contain it).
  - read_en while empty: underflow = 1.
  - clear_stat: both flags and max_count go to 0 the next cycle.
- FIFO_DEPTH=5, READ_MODE=1: continuous streaming of 20 words with 2 held in flight.
  - Expected: pointers wrap 4 -> 0 correctly; each read_valid pulse arrives one cycle after its read_en, with data in order; no underflow.
- Assert rst asynchronously mid-stream at count 7.
  - Expected: all outputs go to reset values immediately, without waiting for a clock edge.
  - A subsequent write then read returns the new data, not stale data.
